// File: rtl/cnt_core.sv
// Enable-gated up-counter with programmable terminal count, one-shot or
// auto-reload behaviour, and registered tc/busy status outputs.
module cnt_core #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         cnt_en_i,
  input  logic         cnt_clr_i,
  input  logic [W-1:0] cnt_thr_i,
  input  logic         cnt_autoreload_i,
  output logic [W-1:0] cnt_val_o,
  output logic         cnt_tc_o,
  output logic         cnt_busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   val_q, val_d;
  logic           tc_q, tc_d;
  logic           busy_q, busy_d;

  // State and output registers; reset wipes any pending tc pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      val_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: clear wins, HALT absorbs, compare is against the current value
  // so a lowered threshold simply waits for the wrap to come back around.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    tc_d    = 1'b0;

    if (cnt_clr_i) begin
      state_d = ST_IDLE;
      val_d   = '0;
    end else if (cnt_en_i && (state_q != ST_HALT)) begin
      if (val_q == cnt_thr_i) begin
        tc_d = 1'b1;
        if (cnt_autoreload_i) begin
          val_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end else begin
        val_d   = val_q + W'(1);
        state_d = ST_RUN;
      end
    end

    busy_d = (state_d == ST_RUN);
  end

  assign cnt_val_o  = val_q;
  assign cnt_tc_o   = tc_q;
  assign cnt_busy_o = busy_q;

endmodule
